// File: rtl/pc_unit.sv
// pc_unit: configurable-width program counter with branch, jump, stall and a circular return-address stack.
// Latency: pc, RAS and flags are registered (one cycle); pc_seq and the RAS-top read are combinational.
// Backpressure: stall freezes all state for the cycle; no other flow control.
//
// Ports: CLK/reset_n (async active-low); controls stall, PCSrc, jump, call, ret; data immediate
// (signed offset), target (absolute address); outputs pc, pc_seq (pc+INC), ras_count, ras_err (sticky).
module pc_unit #(
    parameter int unsigned XLEN      = 8,
    parameter int unsigned INC       = 1,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                             CLK,
    input  logic                             reset_n,
    input  logic                             stall,
    input  logic                             PCSrc,
    input  logic [XLEN-1:0]                  immediate,
    input  logic                             jump,
    input  logic [XLEN-1:0]                  target,
    input  logic                             call,
    input  logic                             ret,
    output logic [XLEN-1:0]                  pc,
    output logic [XLEN-1:0]                  pc_seq,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_err
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

    // wr_ptr is the slot the next push lands in; the top of stack sits one slot below it.
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [XLEN-1:0]  ras_top;

    logic [XLEN-1:0]  pc_next;
    logic [CNT_W-1:0] count_next;
    logic [PTR_W-1:0] ptr_next;
    logic             err_next;
    logic             ras_we;
    logic [PTR_W-1:0] ras_waddr;

    logic ras_empty;
    logic ras_full;
    logic pop_ok;

    assign pc_seq    = pc + XLEN'(INC);
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
    assign pop_ok    = ret && !ras_empty;

    // Explicit wrap so non-power-of-two depths behave as a true circular buffer.
    assign ptr_inc = (wr_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
    assign ptr_dec = (wr_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : wr_ptr - PTR_W'(1);
    assign ras_top = ras_mem[ptr_dec];

    always_comb begin
        pc_next    = pc_seq;
        count_next = ras_count;
        ptr_next   = wr_ptr;
        err_next   = ras_err;
        ras_we     = 1'b0;
        ras_waddr  = wr_ptr;

        // Unsigned add of the two's-complement offset gives the signed result modulo 2^XLEN.
        if (jump) begin
            pc_next = target;
        end else if (PCSrc) begin
            pc_next = pc + immediate;
        end

        if (pop_ok) begin
            pc_next = ras_top;
            if (call) begin
                // Coroutine swap: the popped slot is reused for the new return address.
                ras_we    = 1'b1;
                ras_waddr = ptr_dec;
            end else begin
                ptr_next   = ptr_dec;
                count_next = ras_count - CNT_W'(1);
            end
        end else begin
            // A ret on an empty stack falls through to jump/branch/sequential.
            if (ret) begin
                err_next = 1'b1;
            end
            if (call) begin
                ras_we    = 1'b1;
                ras_waddr = wr_ptr;
                ptr_next  = ptr_inc;
                // When full the push overwrites the oldest entry, so the count saturates.
                if (ras_full) begin
                    err_next = 1'b1;
                end else begin
                    count_next = ras_count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= XLEN'(RESET_VEC);
            ras_count <= '0;
            ras_err   <= 1'b0;
            wr_ptr    <= '0;
        end else if (!stall) begin
            pc        <= pc_next;
            ras_count <= count_next;
            ras_err   <= err_next;
            wr_ptr    <= ptr_next;
        end
    end

    // Entry contents need no reset; validity is tracked by ras_count.
    always_ff @(posedge CLK) begin
        if (reset_n && !stall && ras_we) begin
            ras_mem[ras_waddr] <= pc_seq;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic       CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       stall = 1'b0;
    logic       PCSrc = 1'b0;
    logic [7:0] immediate = 8'h00;
    logic       jump = 1'b0;
    logic [7:0] target = 8'h00;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [7:0] pc;
    logic [7:0] pc_seq;
    logic [2:0] ras_count;
    logic       ras_err;

    pc_unit #(.XLEN(8), .INC(1), .RESET_VEC(0), .RAS_DEPTH(4)) dut (
        .CLK(CLK), .reset_n(reset_n), .stall(stall), .PCSrc(PCSrc),
        .immediate(immediate), .jump(jump), .target(target),
        .call(call), .ret(ret), .pc(pc), .pc_seq(pc_seq),
        .ras_count(ras_count), .ras_err(ras_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int    pc;
        int    seq;
        int    cnt;
        int    err;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic chk_tog = 1'b0;
    bit   done = 1'b0;

    // Reference model: a plain queue holds the return stack, newest at the back.
    int m_pc;
    int m_ras[$];
    int m_err;

    function automatic void model_reset();
        m_pc  = 0;
        m_ras = {};
        m_err = 0;
    endfunction

    function automatic void model_step(input bit s, input bit br, input int imm,
                                       input bit jp, input int tgt, input bit cl, input bit rt);
        int seq;
        int nxt;
        if (s) return;
        seq = (m_pc + 1) % 256;
        if (jp)      nxt = tgt;
        else if (br) nxt = (m_pc + imm) % 256;
        else         nxt = seq;
        if (rt && m_ras.size() > 0) begin
            nxt = m_ras[m_ras.size() - 1];
            if (cl) m_ras[m_ras.size() - 1] = seq;
            else    void'(m_ras.pop_back());
        end else begin
            if (rt) m_err = 1;
            if (cl) begin
                m_ras.push_back(seq);
                if (m_ras.size() > 4) begin
                    void'(m_ras.pop_front());
                    m_err = 1;
                end
            end
        end
        m_pc = nxt;
    endfunction

    function automatic void push_exp(input string tag);
        exp_t e;
        e.pc  = m_pc;
        e.seq = (m_pc + 1) % 256;
        e.cnt = m_ras.size();
        e.err = m_err;
        e.tag = tag;
        exp_q.push_back(e);
    endfunction

    task automatic step(input string tag, input bit s, input bit br, input int imm,
                        input bit jp, input int tgt, input bit cl, input bit rt);
        @(negedge CLK);
        reset_n   = 1'b1;
        stall     = s;
        PCSrc     = br;
        immediate = 8'(imm);
        jump      = jp;
        target    = 8'(tgt);
        call      = cl;
        ret       = rt;
        model_step(s, br, imm, jp, tgt, cl, rt);
        push_exp(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset is pulled between edges and checked immediately, then held across two edges.
    task automatic do_reset();
        @(negedge CLK);
        #2;
        reset_n = 1'b0;
        stall = 0; PCSrc = 0; jump = 0; call = 0; ret = 0;
        model_reset();
        push_exp("async_rst");
        chk_tog = ~chk_tog;
        #2;
        push_exp("in_rst_a");
        @(negedge CLK);
        push_exp("in_rst_b");
    endtask

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every clock edge (or requested async sample) pops one expectation if present.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK or chk_tog);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp({e.tag, ".pc"},        int'(pc),        e.pc);
                cmp({e.tag, ".pc_seq"},    int'(pc_seq),    e.seq);
                cmp({e.tag, ".ras_count"}, int'(ras_count), e.cnt);
                cmp({e.tag, ".ras_err"},   int'(ras_err),   e.err);
            end
        end
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: simulation did not complete, expected finish");
            $fatal(1);
        end
    end

    initial begin
        model_reset();
        do_reset();

        // Sequential run
        repeat (4) idle("seq");
        // Branch backwards by 2, then wrap through 0xFF
        step("branch", 0, 1, 8'hFE, 0, 0, 0, 0);
        step("jmp_fd", 0, 0, 0, 1, 8'hFD, 0, 0);
        repeat (3) idle("wrap");

        // Stall dominates jump+call, then release
        step("jmp10", 0, 0, 0, 1, 10, 0, 0);
        step("stall", 1, 0, 0, 1, 50, 1, 0);
        step("stall2", 1, 1, 3, 0, 0, 0, 1);
        step("unstall", 0, 0, 0, 1, 50, 1, 0);

        // Call/return nesting
        do_reset();
        step("jmp5", 0, 0, 0, 1, 5, 0, 0);
        step("call20", 0, 0, 0, 1, 20, 1, 0);
        step("call40", 0, 0, 0, 1, 40, 1, 0);
        step("ret21", 0, 0, 0, 0, 0, 0, 1);
        step("ret6", 0, 0, 0, 0, 0, 0, 1);

        // Overflow: 5 calls, 4 rets, then underflow
        do_reset();
        for (int i = 0; i < 5; i++) step("ovf_call", 0, 0, 0, 1, 16 * (i + 1), 1, 0);
        for (int i = 0; i < 4; i++) step("ovf_ret", 0, 0, 0, 0, 0, 0, 1);
        step("unf_ret_branch", 0, 1, 8'h10, 0, 0, 0, 1);

        do_reset();
        step("empty_ret", 0, 0, 0, 0, 0, 0, 1);

        // Empty-stack call+ret pushes and flags
        do_reset();
        step("empty_swap", 0, 0, 0, 0, 0, 1, 1);
        step("ret_after", 0, 0, 0, 0, 0, 0, 1);

        // Coroutine swap with top=30
        do_reset();
        step("jmp29", 0, 0, 0, 1, 29, 0, 0);
        step("push30", 0, 0, 0, 0, 0, 1, 0);
        step("jmp12", 0, 0, 0, 1, 12, 0, 0);
        step("swap", 0, 0, 0, 0, 0, 1, 1);
        step("ret13", 0, 0, 0, 0, 0, 0, 1);
        step("jmp12b", 0, 0, 0, 1, 12, 1, 0);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            step("rand",
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        @(negedge CLK);
        @(negedge CLK);
        cmp("drain.queue_left", exp_q.size(), 0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
